// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) and divide (restoring) engine.
// Owns HI/LO; sequenced by a small FSM started from IDLE by one-cycle pulses.
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        MultCtrl,
  input  logic        DivCtrl,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        busy,
  output logic        done,
  output logic        DivZero
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_MULT_RUN = 3'd1;
  localparam logic [2:0] S_DIV_RUN  = 3'd2;
  localparam logic [2:0] S_DIV_FIX  = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [64:0] acc_q, acc_d;
  logic        qm1_q, qm1_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
  logic        sign_q_q, sign_q_d, sign_r_q, sign_r_d;
  logic        dz_q, dz_d;
  logic [4:0]  cnt_q, cnt_d;

  logic [32:0] upper_sum;
  logic [64:0] booth_acc;
  logic [32:0] rem_shift, rem_diff;
  logic [31:0] a_mag, b_mag;

  always_comb begin
    // Upper part is 33 bits so that subtracting -2^31 cannot overflow.
    case ({acc_q[0], qm1_q})
      2'b01:   upper_sum = acc_q[64:32] + {mcand_q[31], mcand_q};
      2'b10:   upper_sum = acc_q[64:32] - {mcand_q[31], mcand_q};
      default: upper_sum = acc_q[64:32];
    endcase
    booth_acc = {upper_sum[32], upper_sum, acc_q[31:1]};
    rem_shift = {rem_q, quo_q[31]};
    rem_diff  = rem_shift - {1'b0, dvsr_q};
    a_mag     = A[31] ? -A : A;
    b_mag     = B[31] ? -B : B;
  end

  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    acc_d    = acc_q;
    qm1_d    = qm1_q;
    mcand_d  = mcand_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    sign_q_d = sign_q_q;
    sign_r_d = sign_r_q;
    dz_d     = dz_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (MultCtrl) begin
          mcand_d = A;
          acc_d   = {33'd0, B};
          qm1_d   = 1'b0;
          cnt_d   = 5'd0;
          dz_d    = 1'b0;
          state_d = S_MULT_RUN;
        end else if (DivCtrl) begin
          if (B == 32'd0) begin
            dz_d    = 1'b1;
            state_d = S_DONE;
          end else begin
            quo_d    = a_mag;
            dvsr_d   = b_mag;
            sign_q_d = A[31] ^ B[31];
            sign_r_d = A[31];
            rem_d    = 32'd0;
            cnt_d    = 5'd0;
            dz_d     = 1'b0;
            state_d  = S_DIV_RUN;
          end
        end
      end
      S_MULT_RUN: begin
        acc_d = booth_acc;
        qm1_d = acc_q[0];
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          hi_d    = booth_acc[63:32];
          lo_d    = booth_acc[31:0];
          state_d = S_DONE;
        end
      end
      S_DIV_RUN: begin
        // A negative trial difference means restore, i.e. keep the shifted value.
        if (!rem_diff[32]) begin
          rem_d = rem_diff[31:0];
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = rem_shift[31:0];
          quo_d = {quo_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_DIV_FIX;
      end
      S_DIV_FIX: begin
        lo_d    = sign_q_q ? -quo_q : quo_q;
        hi_d    = sign_r_q ? -rem_q : rem_q;
        dz_d    = 1'b0;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      acc_q    <= 65'd0;
      qm1_q    <= 1'b0;
      mcand_q  <= 32'd0;
      rem_q    <= 32'd0;
      quo_q    <= 32'd0;
      dvsr_q   <= 32'd0;
      sign_q_q <= 1'b0;
      sign_r_q <= 1'b0;
      dz_q     <= 1'b0;
      cnt_q    <= 5'd0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      acc_q    <= acc_d;
      qm1_q    <= qm1_d;
      mcand_q  <= mcand_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      sign_q_q <= sign_q_d;
      sign_r_q <= sign_r_d;
      dz_q     <= dz_d;
      cnt_q    <= cnt_d;
    end
  end

  assign HI      = hi_q;
  assign LO      = lo_q;
  assign busy    = (state_q == S_MULT_RUN) || (state_q == S_DIV_RUN) || (state_q == S_DIV_FIX);
  assign done    = (state_q == S_DONE);
  assign DivZero = dz_q && (state_q == S_DONE);

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed and random operations against a
// plain-arithmetic model of the HI/LO contents and timing.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MultCtrl = 1'b0;
  logic        DivCtrl = 1'b0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic [31:0] HI, LO;
  logic        busy, done, DivZero;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_hi = 32'd0;
  logic [31:0] model_lo = 32'd0;

  mult_div_unit dut (
    .clk(clk), .reset(reset), .MultCtrl(MultCtrl), .DivCtrl(DivCtrl),
    .A(A), .B(B), .HI(HI), .LO(LO), .busy(busy), .done(done), .DivZero(DivZero)
  );

  always #5 clk = ~clk;

  // Drives one start pulse, then watches the unit until done (bounded).
  // inj > 0 injects a stray MultCtrl pulse sampled on edge inj.
  task automatic run_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                        input int inj, output logic [31:0] hi, output logic [31:0] lo,
                        output int lat, output int bcnt, output logic dz, output logic done_after);
    int e;
    hi = 32'hx; lo = 32'hx; dz = 1'bx; lat = -1; bcnt = 0;
    @(negedge clk);
    MultCtrl = m; DivCtrl = d; A = a; B = b;
    @(posedge clk); #1;
    MultCtrl = 1'b0; DivCtrl = 1'b0; A = $urandom; B = $urandom;
    e = 0;
    while (e < 80) begin
      if (busy) bcnt++;
      if (done) begin
        lat = e; hi = HI; lo = LO; dz = DivZero;
        break;
      end
      MultCtrl = (inj > 0) && (e == inj - 1);
      if (MultCtrl) begin A = $urandom; B = $urandom; end
      @(posedge clk); #1;
      MultCtrl = 1'b0;
      e++;
    end
    @(posedge clk); #1;
    done_after = done;
  endtask

  task automatic test_txn(input string name, input logic m, input logic d,
                          input logic [31:0] a, input logic [31:0] b, input int inj);
    logic [31:0] hi, lo;
    int lat, bcnt, elat;
    logic dz, da, edz;
    longint sa, sb, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (m) begin
      p = sa * sb; model_hi = p[63:32]; model_lo = p[31:0]; elat = 32; edz = 1'b0;
    end else if (b == 32'd0) begin
      elat = 0; edz = 1'b1;
    end else begin
      p = sa / sb; model_lo = p[31:0];
      p = sa % sb; model_hi = p[31:0];
      elat = 33; edz = 1'b0;
    end
    run_op(m, d, a, b, inj, hi, lo, lat, bcnt, dz, da);
    $display("%s m=%0b d=%0b A=%h B=%h -> HI=%h LO=%h lat=%0d busy=%0d dz=%0b",
             name, m, d, a, b, hi, lo, lat, bcnt, dz);
    checks++; if (hi !== model_hi) begin errors++; $display("FAIL %s HI got %h exp %h", name, hi, model_hi); end
    checks++; if (lo !== model_lo) begin errors++; $display("FAIL %s LO got %h exp %h", name, lo, model_lo); end
    checks++; if (lat !== elat) begin errors++; $display("FAIL %s latency got %0d exp %0d", name, lat, elat); end
    checks++; if (bcnt !== elat) begin errors++; $display("FAIL %s busy_cycles got %0d exp %0d", name, bcnt, elat); end
    checks++; if (dz !== edz) begin errors++; $display("FAIL %s DivZero got %b exp %b", name, dz, edz); end
    checks++; if (da !== 1'b0) begin errors++; $display("FAIL %s done_one_cycle got %b exp 0", name, da); end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (HI !== 32'd0) begin errors++; $display("FAIL reset_HI got %h exp 0", HI); end
    checks++; if (LO !== 32'd0) begin errors++; $display("FAIL reset_LO got %h exp 0", LO); end
    checks++; if ({busy, done, DivZero} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got %b exp 000", {busy, done, DivZero});
    end
    @(negedge clk);
    reset = 1'b1;
    $display("reset released");
  endtask

  task automatic test_mult_directed();
    logic [31:0] ta [5] = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h12345678};
    logic [31:0] tb [5] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0};
    for (int i = 0; i < 5; i++) test_txn("mult_dir", 1'b1, 1'b0, ta[i], tb[i], 0);
  endtask

  task automatic test_div_directed();
    logic [31:0] ta [6] = '{32'hFFFFFFF9, 32'h80000000, 32'd7, 32'd100, 32'hFFFFFFFF, 32'd0};
    logic [31:0] tb [6] = '{32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd7, 32'h80000000, 32'd5};
    for (int i = 0; i < 6; i++) test_txn("div_dir", 1'b0, 1'b1, ta[i], tb[i], 0);
  endtask

  task automatic test_divzero();
    logic [31:0] pa;
    pa = $urandom | 32'h1;
    test_txn("dz_prior_mult", 1'b1, 1'b0, pa, 32'h9ABCDEF1, 0);
    test_txn("divzero", 1'b0, 1'b1, $urandom, 32'd0, 0);
    test_txn("div_after_dz", 1'b0, 1'b1, 32'd1000, 32'd33, 0);
  endtask

  task automatic test_both_and_ignore();
    test_txn("both_ctrl", 1'b1, 1'b1, 32'hFFFF0001, 32'd12345, 0);
    test_txn("ignore_start_mult", 1'b1, 1'b0, 32'h00C0FFEE, 32'hDEADBEEF, 10);
    test_txn("ignore_start_div", 1'b0, 1'b1, 32'h87654321, 32'd977, 10);
  endtask

  task automatic test_random();
    int op;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 3);
      a = $urandom;
      b = $urandom;
      case (op)
        0: test_txn("rnd_mult", 1'b1, 1'b0, a, b, 0);
        1: test_txn("rnd_div", 1'b0, 1'b1, a, (b == 32'd0) ? 32'd1 : b, 0);
        2: test_txn("rnd_both", 1'b1, 1'b1, a, b, 0);
        default: test_txn("rnd_div_small", 1'b0, 1'b1, a, $urandom_range(0, 3) | ({32{a[0]}} << 2), 0);
      endcase
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    DivCtrl = 1'b1; A = 32'h7FFF1234; B = 32'd17;
    @(posedge clk); #1;
    DivCtrl = 1'b0;
    repeat (15) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    model_hi = 32'd0;
    model_lo = 32'd0;
    $display("reset asserted mid-divide HI=%h LO=%h busy=%b", HI, LO, busy);
    checks++; if (HI !== 32'd0) begin errors++; $display("FAIL midreset_HI got %h exp 0", HI); end
    checks++; if (LO !== 32'd0) begin errors++; $display("FAIL midreset_LO got %h exp 0", LO); end
    checks++; if ({busy, done, DivZero} !== 3'b000) begin
      errors++; $display("FAIL midreset_flags got %b exp 000", {busy, done, DivZero});
    end
    @(negedge clk);
    reset = 1'b1;
    test_txn("mult_after_reset", 1'b1, 1'b0, 32'd3, 32'd5, 0);
  endtask

  initial begin
    test_reset();
    test_mult_directed();
    test_div_directed();
    test_divzero();
    test_both_and_ignore();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
